// File: rtl/inj_scan_sequencer.sv
// Injection scan sequencer: issues N gated charge-injection pulses at a programmable
// period, with TDC gate margins, readout back-pressure and clean abort handling.
module inj_scan_sequencer #(
  parameter int CNT_WIDTH    = 16,
  parameter int PERIOD_WIDTH = 16,
  parameter int PHASE_WIDTH  = 8
) (
  input  logic                    CLK40,
  input  logic                    nRST,
  input  logic                    START,
  input  logic                    STOP,
  input  logic                    HOLD,
  input  logic [CNT_WIDTH-1:0]    N_PULSES,
  input  logic [PERIOD_WIDTH-1:0] PERIOD,
  input  logic [PERIOD_WIDTH-1:0] INIT_DELAY,
  input  logic [PHASE_WIDTH-1:0]  GATE_PRE,
  input  logic [PHASE_WIDTH-1:0]  WIDTH,
  input  logic [PHASE_WIDTH-1:0]  GATE_POST,
  output logic                    INJ_PULSE,
  output logic                    GATE_TDC,
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    ABORTED,
  output logic [CNT_WIDTH-1:0]    PULSE_CNT
);

  // Offset counter must hold both the period and a full gate window (3 phases).
  localparam int OW = ((PERIOD_WIDTH > PHASE_WIDTH + 2) ? PERIOD_WIDTH : PHASE_WIDTH + 2) + 1;

  typedef enum logic [2:0] {IDLE, DELAY, ARM, PRE, PULSE, POST, GAP} state_t;

  state_t               state, state_nx;
  logic [OW-1:0]        off, off_nx, n;
  logic [CNT_WIDTH-1:0] cnt_nx, npulse_r;
  logic [OW-1:0]        pre_r, prew_r, win_r, per_r, dly_r;
  logic [OW-1:0]        pre_in, w_in, prew_in, win_in, per_in;
  logic [OW-1:0]        l_pre, l_prew, l_win;
  logic                 stop_pend, stop_pend_nx, aborted_nx;
  logic                 start_ok;

  // Window boundaries derived from the raw config inputs; only used at START acceptance.
  always_comb begin
    pre_in  = OW'(GATE_PRE);
    w_in    = (WIDTH == '0) ? OW'(1) : OW'(WIDTH);
    prew_in = pre_in + w_in;
    win_in  = prew_in + OW'(GATE_POST);
    per_in  = (OW'(PERIOD) > win_in) ? OW'(PERIOD) : win_in + OW'(1);
  end

  assign start_ok = (state == IDLE) && START && !STOP;

  // A zero-delay start launches the gate in the same edge, before config is registered.
  always_comb begin
    l_pre  = start_ok ? pre_in  : pre_r;
    l_prew = start_ok ? prew_in : prew_r;
    l_win  = start_ok ? win_in  : win_r;
  end

  function automatic state_t phase_of(input logic [OW-1:0] o, input logic [OW-1:0] p,
                                      input logic [OW-1:0] pw, input logic [OW-1:0] w);
    if (o < p)       return PRE;
    else if (o < pw) return PULSE;
    else if (o < w)  return POST;
    else             return GAP;
  endfunction

  always_comb begin
    state_nx     = state;
    off_nx       = off;
    cnt_nx       = PULSE_CNT;
    stop_pend_nx = stop_pend;
    aborted_nx   = ABORTED;
    n            = off + OW'(1);
    unique case (state)
      IDLE: begin
        if (start_ok) begin
          cnt_nx       = '0;
          aborted_nx   = 1'b0;
          stop_pend_nx = 1'b0;
          off_nx       = '0;
          if (INIT_DELAY != '0) state_nx = DELAY;
          else if (HOLD)        state_nx = ARM;
          else                  state_nx = phase_of('0, l_pre, l_prew, l_win);
        end
      end
      DELAY, ARM, GAP: begin
        if (STOP) begin
          state_nx   = IDLE;
          aborted_nx = 1'b1;
        end else if ((state == ARM) || (state == DELAY && n == dly_r) ||
                     (state == GAP && n == per_r)) begin
          // Period boundary: the ARM decision is resolved in the same edge.
          off_nx   = '0;
          state_nx = HOLD ? ARM : phase_of('0, l_pre, l_prew, l_win);
        end else begin
          off_nx = n;
        end
      end
      PRE, PULSE, POST: begin
        if (state == PULSE && n >= prew_r) cnt_nx = PULSE_CNT + CNT_WIDTH'(1);
        if (state != PRE) stop_pend_nx = stop_pend | STOP;
        if (state == PRE && STOP) begin
          state_nx   = IDLE;
          aborted_nx = 1'b1;
        end else if (n < win_r) begin
          off_nx   = n;
          state_nx = phase_of(n, pre_r, prew_r, win_r);
        end else if (stop_pend_nx) begin
          state_nx   = IDLE;
          aborted_nx = 1'b1;
        end else if (npulse_r != '0 && cnt_nx == npulse_r) begin
          state_nx = IDLE;
        end else begin
          off_nx   = n;
          state_nx = GAP;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK40 or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      off       <= '0;
      stop_pend <= 1'b0;
      INJ_PULSE <= 1'b0;
      GATE_TDC  <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      ABORTED   <= 1'b0;
      PULSE_CNT <= '0;
    end else begin
      state     <= state_nx;
      off       <= off_nx;
      stop_pend <= stop_pend_nx;
      INJ_PULSE <= (state_nx == PULSE);
      GATE_TDC  <= (state_nx == PRE) || (state_nx == PULSE) || (state_nx == POST);
      BUSY      <= (state_nx != IDLE);
      DONE      <= (state != IDLE) && (state_nx == IDLE);
      ABORTED   <= aborted_nx;
      PULSE_CNT <= cnt_nx;
    end
  end

  always_ff @(posedge CLK40 or negedge nRST) begin
    if (!nRST) begin
      npulse_r <= '0;
      pre_r    <= '0;
      prew_r   <= '0;
      win_r    <= '0;
      per_r    <= '0;
      dly_r    <= '0;
    end else if (start_ok) begin
      npulse_r <= N_PULSES;
      pre_r    <= pre_in;
      prew_r   <= prew_in;
      win_r    <= win_in;
      per_r    <= per_in;
      dly_r    <= OW'(INIT_DELAY);
    end
  end

endmodule

// File: tb/tb_inj_scan_sequencer.sv
// Directed bench for inj_scan_sequencer: per-cycle traces compared against hand-built masks.
// Trace bit k holds the output observed just after the k-th edge, edge 0 being the START edge.
module tb_inj_scan_sequencer;

  logic        CLK40 = 1'b0;
  logic        nRST, START, STOP, HOLD;
  logic [15:0] N_PULSES, PERIOD, INIT_DELAY;
  logic [7:0]  GATE_PRE, WIDTH, GATE_POST;
  logic        INJ_PULSE, GATE_TDC, BUSY, DONE, ABORTED;
  logic [15:0] PULSE_CNT;

  logic        start_c, stop_c;
  logic [3:0]  n_c, cnt_c;
  logic        inj_c, gate_c, busy_c, done_c, ab_c;

  int n_tests = 0;
  int n_fail  = 0;
  int ndone;
  logic [63:0] gate_tr, inj_tr, busy_tr, done_tr;

  always #5 CLK40 = ~CLK40;

  inj_scan_sequencer u_dut (
    .CLK40(CLK40), .nRST(nRST), .START(START), .STOP(STOP), .HOLD(HOLD),
    .N_PULSES(N_PULSES), .PERIOD(PERIOD), .INIT_DELAY(INIT_DELAY),
    .GATE_PRE(GATE_PRE), .WIDTH(WIDTH), .GATE_POST(GATE_POST),
    .INJ_PULSE(INJ_PULSE), .GATE_TDC(GATE_TDC), .BUSY(BUSY), .DONE(DONE),
    .ABORTED(ABORTED), .PULSE_CNT(PULSE_CNT)
  );

  inj_scan_sequencer #(.CNT_WIDTH(4), .PERIOD_WIDTH(16), .PHASE_WIDTH(8)) u_cont (
    .CLK40(CLK40), .nRST(nRST), .START(start_c), .STOP(stop_c), .HOLD(1'b0),
    .N_PULSES(n_c), .PERIOD(PERIOD), .INIT_DELAY(INIT_DELAY),
    .GATE_PRE(GATE_PRE), .WIDTH(WIDTH), .GATE_POST(GATE_POST),
    .INJ_PULSE(inj_c), .GATE_TDC(gate_c), .BUSY(busy_c), .DONE(done_c),
    .ABORTED(ab_c), .PULSE_CNT(cnt_c)
  );

  function automatic logic [63:0] m(input int lo, input int hi);
    logic [63:0] r;
    r = '0;
    for (int i = lo; i <= hi; i++) r[i] = 1'b1;
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input int np, input int per, input int dly,
                     input int pre, input int w, input int post);
    N_PULSES   = 16'(np);
    PERIOD     = 16'(per);
    INIT_DELAY = 16'(dly);
    GATE_PRE   = 8'(pre);
    WIDTH      = 8'(w);
    GATE_POST  = 8'(post);
  endtask

  // START at edge 0; optional STOP edge, HOLD edge range, and config/START meddling while busy.
  task automatic scan(input int ncyc, input int stop_k, input int hold_lo, input int hold_hi,
                      input bit meddle);
    gate_tr = '0; inj_tr = '0; busy_tr = '0; done_tr = '0;
    for (int k = 0; k < ncyc; k++) begin
      START = (k == 0) || (meddle && k == 3);
      STOP  = (k == stop_k);
      HOLD  = (k >= hold_lo) && (k <= hold_hi);
      if (meddle && k == 1) cfg(1, 3, 5, 0, 7, 4);
      @(posedge CLK40); #1;
      gate_tr[k] = GATE_TDC;
      inj_tr[k]  = INJ_PULSE;
      busy_tr[k] = BUSY;
      done_tr[k] = DONE;
    end
    START = 1'b0; STOP = 1'b0; HOLD = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    nRST = 1'b0; START = 1'b0; STOP = 1'b0; HOLD = 1'b0;
    start_c = 1'b0; stop_c = 1'b0; n_c = 4'd0;
    cfg(3, 10, 0, 2, 3, 1);
    repeat (3) @(posedge CLK40);
    #1;
    check("reset_outputs", 64'({INJ_PULSE, GATE_TDC, BUSY, DONE, ABORTED, PULSE_CNT}), 64'd0);
    nRST = 1'b1;
    @(posedge CLK40); #1;

    // Normal scan, with config changes and a second START while busy (both ignored)
    cfg(3, 10, 0, 2, 3, 1);
    scan(30, -1, -1, -1, 1'b1);
    check("norm_gate", gate_tr, m(0, 5) | m(10, 15) | m(20, 25));
    check("norm_inj",  inj_tr,  m(2, 4) | m(12, 14) | m(22, 24));
    check("norm_busy", busy_tr, m(0, 25));
    check("norm_done", done_tr, m(26, 26));
    check("norm_cnt",  64'(PULSE_CNT), 64'd3);
    check("norm_abort", 64'(ABORTED), 64'd0);

    // Period clamped to GATE_PRE+W+GATE_POST+1 = 7
    cfg(3, 4, 0, 2, 3, 1);
    scan(24, -1, -1, -1, 1'b0);
    check("clamp_gate", gate_tr, m(0, 5) | m(7, 12) | m(14, 19));
    check("clamp_done", done_tr, m(20, 20));

    // Back-pressure: HOLD sampled high on edges 8..13, only the ARM samples (10..13) matter
    cfg(3, 10, 0, 2, 3, 1);
    scan(34, -1, 8, 13, 1'b0);
    check("hold_gate", gate_tr, m(0, 5) | m(14, 19) | m(24, 29));
    check("hold_inj",  inj_tr,  m(2, 4) | m(16, 18) | m(26, 28));
    check("hold_done", done_tr, m(30, 30));
    check("hold_cnt",  64'(PULSE_CNT), 64'd3);

    // STOP inside the pulse: pulse and post margin complete
    cfg(3, 10, 0, 2, 3, 1);
    scan(12, 4, -1, -1, 1'b0);
    check("abp_inj",  inj_tr,  m(2, 4));
    check("abp_gate", gate_tr, m(0, 5));
    check("abp_done", done_tr, m(6, 6));
    check("abp_cnt",  64'(PULSE_CNT), 64'd1);
    check("abp_abort", 64'(ABORTED), 64'd1);

    // STOP during the gap: no further gate, DONE shortly after
    cfg(3, 10, 0, 2, 3, 1);
    scan(20, 8, -1, -1, 1'b0);
    check("abg_gate", gate_tr, m(0, 5));
    check("abg_done_win", done_tr & ~m(8, 9), 64'd0);
    check("abg_done_cnt", 64'($countones(done_tr)), 64'd1);
    check("abg_abort", 64'(ABORTED), 64'd1);

    // WIDTH=0 behaves as a one-cycle pulse; ABORTED cleared by the new START
    cfg(2, 10, 0, 2, 0, 1);
    scan(18, -1, -1, -1, 1'b0);
    check("w0_inj",  inj_tr,  m(2, 2) | m(12, 12));
    check("w0_gate", gate_tr, m(0, 3) | m(10, 13));
    check("w0_done", done_tr, m(14, 14));
    check("w0_abort", 64'(ABORTED), 64'd0);

    // INIT_DELAY=3 with zero margins
    cfg(1, 10, 3, 0, 2, 0);
    scan(8, -1, -1, -1, 1'b0);
    check("dly_busy", busy_tr, m(0, 4));
    check("dly_gate", gate_tr, m(3, 4));
    check("dly_inj",  inj_tr,  m(3, 4));
    check("dly_done", done_tr, m(5, 5));

    // START and STOP together in IDLE: STOP wins
    cfg(3, 10, 0, 2, 3, 1);
    scan(6, 0, -1, -1, 1'b0);
    check("ss_busy", busy_tr, 64'd0);
    check("ss_done", done_tr, 64'd0);

    // Asynchronous reset in the middle of a pulse
    cfg(3, 10, 0, 2, 3, 1);
    scan(3, -1, -1, -1, 1'b0);
    check("rst_pre_inj", 64'(INJ_PULSE), 64'd1);
    #2 nRST = 1'b0;
    #1;
    check("rst_async", 64'({INJ_PULSE, GATE_TDC, BUSY, DONE, ABORTED, PULSE_CNT}), 64'd0);
    @(posedge CLK40); #1;
    nRST = 1'b1;
    @(posedge CLK40); #1;

    // Continuous mode on the 4-bit counter build: wraps 15 -> 0 on the 16th pulse
    cfg(0, 10, 0, 2, 3, 1);
    start_c = 1'b1;
    @(posedge CLK40); #1;
    start_c = 1'b0;
    for (int k = 1; k <= 155; k++) begin
      @(posedge CLK40); #1;
      if (k == 154) check("cont_cnt15", 64'(cnt_c), 64'd15);
      if (k == 155) begin
        check("cont_wrap", 64'(cnt_c), 64'd0);
        check("cont_busy", 64'(busy_c), 64'd1);
      end
    end
    stop_c = 1'b1;
    ndone  = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge CLK40); #1;
      stop_c = 1'b0;
      if (done_c) ndone++;
    end
    check("cont_stop_done", 64'(ndone), 64'd1);
    check("cont_stop_busy", 64'(busy_c), 64'd0);
    check("cont_stop_abort", 64'(ab_c), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
